// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter
//
// Shares the Panel framebuffer write port between a single-word CPU
// requester and a built-in rectangle fill engine. At most one write per
// clock reaches the framebuffer. The write port outputs are registered
// and connect straight to the Panel write inputs.
//
// Ports:
//   clock         - system clock, rising edge
//   reset_n       - asynchronous active-low reset
//   cpu_req       - CPU write request, held until cpu_ack
//   cpu_address   - CPU write address (passed through unchecked)
//   cpu_value     - CPU write data
//   cpu_ack       - combinational grant for the CPU request
//   fill_start    - one-cycle pulse starting a rectangle fill (IDLE only)
//   fill_x/fill_y - top-left corner of the rectangle
//   fill_w/fill_h - rectangle size in pixels (clipped to the panel)
//   fill_color    - fill value
//   fill_busy     - registered, high from the cycle after fill_start
//                   through the fill_done cycle
//   fill_done     - registered one-cycle completion pulse
//   write_address - registered framebuffer write address
//   write_value   - registered framebuffer write data
//   we            - registered framebuffer write strobe
//
// WIDTH*HEIGHT must not exceed 2**ADDR_W.

module panel_write_arbiter #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 16,
   parameter int ADDR_W = 16,
   parameter int X_W    = 7,
   parameter int Y_W    = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [15:0]       cpu_value,
   output logic              cpu_ack,
   input  logic              fill_start,
   input  logic [X_W-1:0]    fill_x,
   input  logic [Y_W-1:0]    fill_y,
   input  logic [X_W-1:0]    fill_w,
   input  logic [Y_W-1:0]    fill_h,
   input  logic [15:0]       fill_color,
   output logic              fill_busy,
   output logic              fill_done,
   output logic [ADDR_W-1:0] write_address,
   output logic [15:0]       write_value,
   output logic              we
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_DONE
   } state_t;

   // Panel extents at one bit wider than the coordinates so that x+w and
   // y+h cannot wrap before they are compared.
   localparam logic [X_W:0] WIDTH_EXT  = (X_W+1)'(WIDTH);
   localparam logic [Y_W:0] HEIGHT_EXT = (Y_W+1)'(HEIGHT);

   state_t state, next_state;

   // Latched fill geometry and cursor.
   logic [X_W-1:0] start_x;
   logic [X_W-1:0] x_end;
   logic [Y_W-1:0] y_end;
   logic [X_W-1:0] cur_x;
   logic [Y_W-1:0] cur_y;
   logic [15:0]    color;

   // 1: the fill engine won the most recent contended cycle.
   logic last_grant_fill;

   logic [X_W:0]      x_sum;
   logic [Y_W:0]      y_sum;
   logic [X_W-1:0]    x_end_clip;
   logic [Y_W-1:0]    y_end_clip;
   logic              degenerate;
   logic              fill_pending;
   logic              contended;
   logic              grant_cpu;
   logic              grant_fill;
   logic              last_pixel;
   logic [ADDR_W-1:0] fill_address;

   // ------------------------------------------------------------------
   // Start-of-fill clipping
   // ------------------------------------------------------------------
   always_comb begin
      x_sum      = {1'b0, fill_x} + {1'b0, fill_w};
      y_sum      = {1'b0, fill_y} + {1'b0, fill_h};
      x_end_clip = X_W'((x_sum > WIDTH_EXT)  ? WIDTH_EXT  - 1'b1 : x_sum - 1'b1);
      y_end_clip = Y_W'((y_sum > HEIGHT_EXT) ? HEIGHT_EXT - 1'b1 : y_sum - 1'b1);
      degenerate = (fill_w == '0) || (fill_h == '0) ||
                   ({1'b0, fill_x} >= WIDTH_EXT) ||
                   ({1'b0, fill_y} >= HEIGHT_EXT);
   end

   // ------------------------------------------------------------------
   // Arbitration: a lone candidate always wins; on contention the side
   // that did not win the previous contention gets the port, so the two
   // alternate strictly and neither starves.
   // ------------------------------------------------------------------
   always_comb begin
      fill_pending = (state == ST_FILL);
      contended    = cpu_req && fill_pending;
      grant_cpu    = cpu_req && (!fill_pending || last_grant_fill);
      grant_fill   = fill_pending && (!cpu_req || !last_grant_fill);
      cpu_ack      = grant_cpu;
   end

   assign last_pixel   = (cur_x == x_end) && (cur_y == y_end);
   assign fill_address = ADDR_W'(cur_y) * ADDR_W'(WIDTH) + ADDR_W'(cur_x);

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (fill_start) begin
               next_state = degenerate ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (grant_fill && last_pixel) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM state and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its inputs from before the clock edge.
         state     <= ST_IDLE;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
      end else begin
         state     <= next_state;
         fill_busy <= (next_state != ST_IDLE);
         fill_done <= (next_state == ST_DONE);
      end
   end

   // ------------------------------------------------------------------
   // Fill geometry latch and row-major cursor
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_x <= '0;
         x_end   <= '0;
         y_end   <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         color   <= '0;
      end else if (state == ST_IDLE && fill_start) begin
         start_x <= fill_x;
         x_end   <= x_end_clip;
         y_end   <= y_end_clip;
         cur_x   <= fill_x;
         cur_y   <= fill_y;
         color   <= fill_color;
      end else if (grant_fill) begin
         if (cur_x == x_end) begin
            cur_x <= start_x;
            cur_y <= cur_y + 1'b1;
         end else begin
            cur_x <= cur_x + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Contention history
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_fill <= 1'b1;
      end else if (contended) begin
         last_grant_fill <= grant_fill;
      end
   end

   // ------------------------------------------------------------------
   // Registered write port: a grant in cycle N writes in cycle N+1.
   // Address and value hold when there is no write.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we            <= 1'b0;
         write_address <= '0;
         write_value   <= '0;
      end else if (grant_cpu) begin
         we            <= 1'b1;
         write_address <= cpu_address;
         write_value   <= cpu_value;
      end else if (grant_fill) begin
         we            <= 1'b1;
         write_address <= fill_address;
         write_value   <= color;
      end else begin
         we            <= 1'b0;
      end
   end

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Testbench for panel_write_arbiter: expected writes are queued when the
// stimulus is driven and compared in order as the DUT strobes we.

module tb_panel_write_arbiter;

   localparam int WIDTH  = 32;
   localparam int HEIGHT = 16;
   localparam int ADDR_W = 16;
   localparam int X_W    = 7;
   localparam int Y_W    = 5;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_address;
   logic [15:0]       cpu_value;
   logic              cpu_ack;
   logic              fill_start;
   logic [X_W-1:0]    fill_x;
   logic [Y_W-1:0]    fill_y;
   logic [X_W-1:0]    fill_w;
   logic [Y_W-1:0]    fill_h;
   logic [15:0]       fill_color;
   logic              fill_busy;
   logic              fill_done;
   logic [ADDR_W-1:0] write_address;
   logic [15:0]       write_value;
   logic              we;

   always #5 clock = ~clock;

   panel_write_arbiter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .ADDR_W(ADDR_W),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .cpu_req      (cpu_req),
      .cpu_address  (cpu_address),
      .cpu_value    (cpu_value),
      .cpu_ack      (cpu_ack),
      .fill_start   (fill_start),
      .fill_x       (fill_x),
      .fill_y       (fill_y),
      .fill_w       (fill_w),
      .fill_h       (fill_h),
      .fill_color   (fill_color),
      .fill_busy    (fill_busy),
      .fill_done    (fill_done),
      .write_address(write_address),
      .write_value  (write_value),
      .we           (we)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] value;
   } wr_t;

   wr_t exp_q[$];
   int  total       = 0;
   int  passed      = 0;
   int  write_count = 0;
   int  done_count  = 0;

   // Scoreboard monitor: every write must match the head of the queue.
   always @(negedge clock) begin
      wr_t e;
      if (reset_n === 1'b1 && fill_done === 1'b1) done_count++;
      if (reset_n === 1'b1 && we === 1'b1) begin
         write_count++;
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got addr=%h value=%h, required no write",
                     write_address, write_value);
         end else begin
            e = exp_q.pop_front();
            if (write_address !== e.addr || write_value !== e.value)
               $display("FAIL write_data: got addr=%h value=%h, required addr=%h value=%h",
                        write_address, write_value, e.addr, e.value);
            else
               passed++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model for a fill: row-major, clipped to the panel.
   task automatic push_fill(input int x, input int y, input int w, input int h,
                            input logic [15:0] color);
      int xe;
      int ye;
      xe = (x + w > WIDTH)  ? WIDTH  : x + w;
      ye = (y + h > HEIGHT) ? HEIGHT : y + h;
      for (int yy = y; yy < ye; yy++)
         for (int xx = x; xx < xe; xx++)
            exp_q.push_back('{16'(yy * WIDTH + xx), color});
   endtask

   task automatic drive_fill(input int x, input int y, input int w, input int h,
                             input logic [15:0] color);
      fill_start = 1'b1;
      fill_x     = X_W'(x);
      fill_y     = Y_W'(y);
      fill_w     = X_W'(w);
      fill_h     = Y_W'(h);
      fill_color = color;
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fill_busy !== 1'b0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= 200)
         $display("FAIL %s_timeout: got %0d writes pending busy=%b, required 0 pending busy=0",
                  name, exp_q.size(), fill_busy);
      else
         passed++;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      cpu_req     = 1'b1;
      cpu_address = 16'hFFFF;
      cpu_value   = 16'hFFFF;
      drive_fill(1, 1, 4, 4, 16'hFFFF);
      repeat (3) @(negedge clock);
      total++; if (we !== 1'b0) $display("FAIL reset_we: got %b, required 0", we); else passed++;
      total++; if (write_address !== '0) $display("FAIL reset_addr: got %h, required 0", write_address); else passed++;
      total++; if (write_value !== '0) $display("FAIL reset_value: got %h, required 0", write_value); else passed++;
      total++; if (fill_busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", fill_busy); else passed++;
      total++; if (fill_done !== 1'b0) $display("FAIL reset_done: got %b, required 0", fill_done); else passed++;
      tick();
      cpu_req    = 1'b0;
      fill_start = 1'b0;
      reset_n    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++;
         if (we !== 1'b0 || fill_busy !== 1'b0)
            $display("FAIL idle_quiet: got we=%b busy=%b, required 0 0", we, fill_busy);
         else passed++;
      end
   endtask

   task automatic test_cpu_single();
      int w0;
      w0 = write_count;
      tick();
      cpu_req = 1'b1; cpu_address = 16'h0041; cpu_value = 16'h0007;
      exp_q.push_back('{16'h0041, 16'h0007});
      @(negedge clock);
      total++; if (cpu_ack !== 1'b1) $display("FAIL cpu_ack_same_cycle: got %b, required 1", cpu_ack); else passed++;
      tick();
      cpu_req = 1'b0;
      @(negedge clock);
      total++; if (we !== 1'b1) $display("FAIL cpu_we_next: got %b, required 1", we); else passed++;
      @(negedge clock);
      total++; if (we !== 1'b0) $display("FAIL cpu_we_one_cycle: got %b, required 0", we); else passed++;
      // back-to-back requests
      tick();
      cpu_req = 1'b1; cpu_address = 16'h0100; cpu_value = 16'hBEEF;
      exp_q.push_back('{16'h0100, 16'hBEEF});
      @(negedge clock);
      total++; if (cpu_ack !== 1'b1) $display("FAIL b2b_ack1: got %b, required 1", cpu_ack); else passed++;
      tick();
      cpu_address = 16'h0101; cpu_value = 16'hCAFE;
      exp_q.push_back('{16'h0101, 16'hCAFE});
      @(negedge clock);
      total++; if (cpu_ack !== 1'b1 || we !== 1'b1)
         $display("FAIL b2b_ack2: got ack=%b we=%b, required 1 1", cpu_ack, we); else passed++;
      tick();
      cpu_req = 1'b0;
      @(negedge clock);
      total++; if (we !== 1'b1) $display("FAIL b2b_we2: got %b, required 1", we); else passed++;
      wait_quiet("cpu");
      total++; if (write_count - w0 != 3)
         $display("FAIL cpu_write_count: got %0d, required 3", write_count - w0); else passed++;
   endtask

   task automatic test_fill_basic();
      int w0;
      int d0;
      w0 = write_count; d0 = done_count;
      tick();
      drive_fill(3, 1, 2, 2, 16'h0005);
      push_fill(3, 1, 2, 2, 16'h0005);
      tick();
      fill_start = 1'b0;
      @(negedge clock);
      total++; if (fill_busy !== 1'b1) $display("FAIL fill_busy_rise: got %b, required 1", fill_busy); else passed++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total++; if (we !== 1'b1) $display("FAIL fill_we_consecutive: got %b at pixel %0d, required 1", we, i); else passed++;
         total++;
         if (fill_done !== (i == 3))
            $display("FAIL fill_done_timing: got %b at pixel %0d, required %b", fill_done, i, (i == 3));
         else passed++;
      end
      total++; if (write_address !== 16'd68) $display("FAIL fill_done_addr: got %0d, required 68", write_address); else passed++;
      @(negedge clock);
      total++; if (fill_busy !== 1'b0 || fill_done !== 1'b0)
         $display("FAIL fill_busy_fall: got busy=%b done=%b, required 0 0", fill_busy, fill_done); else passed++;
      wait_quiet("fill");
      total++; if (write_count - w0 != 4 || done_count - d0 != 1)
         $display("FAIL fill_counts: got writes=%0d dones=%0d, required 4 1", write_count - w0, done_count - d0); else passed++;
   endtask

   task automatic test_clip_degenerate();
      int w0;
      w0 = write_count;
      tick();
      drive_fill(30, 15, 5, 4, 16'h0ABC);
      push_fill(30, 15, 5, 4, 16'h0ABC);
      tick();
      fill_start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      total++; if (we !== 1'b1 || fill_done !== 1'b0)
         $display("FAIL clip_first: got we=%b done=%b, required 1 0", we, fill_done); else passed++;
      @(negedge clock);
      total++; if (we !== 1'b1 || fill_done !== 1'b1 || write_address !== 16'd511)
         $display("FAIL clip_last: got we=%b done=%b addr=%0d, required 1 1 511", we, fill_done, write_address); else passed++;
      wait_quiet("clip");
      total++; if (write_count - w0 != 2)
         $display("FAIL clip_count: got %0d, required 2", write_count - w0); else passed++;
      // degenerate: zero width
      tick();
      drive_fill(4, 2, 0, 3, 16'h0111);
      tick();
      fill_start = 1'b0;
      @(negedge clock);
      total++; if (fill_done !== 1'b1 || we !== 1'b0 || fill_busy !== 1'b1)
         $display("FAIL degenerate_done: got done=%b we=%b busy=%b, required 1 0 1", fill_done, we, fill_busy); else passed++;
      @(negedge clock);
      total++; if (fill_busy !== 1'b0 || we !== 1'b0)
         $display("FAIL degenerate_after: got busy=%b we=%b, required 0 0", fill_busy, we); else passed++;
   endtask

   task automatic test_contention();
      logic exp_ack[5];
      logic got;
      int   ci;
      int   w0;
      int   d0;
      exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      w0 = write_count; d0 = done_count; ci = 0;
      tick();
      drive_fill(0, 2, 4, 1, 16'h1111);
      exp_q.push_back('{16'h0100, 16'hC000});
      exp_q.push_back('{16'd64,   16'h1111});
      exp_q.push_back('{16'h0101, 16'hC001});
      exp_q.push_back('{16'd65,   16'h1111});
      exp_q.push_back('{16'h0102, 16'hC002});
      exp_q.push_back('{16'd66,   16'h1111});
      exp_q.push_back('{16'd67,   16'h1111});
      tick();
      fill_start = 1'b0;
      cpu_req = 1'b1; cpu_address = 16'h0100; cpu_value = 16'hC000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         got = cpu_ack;
         total++; if (cpu_ack !== exp_ack[i])
            $display("FAIL contention_ack: got %b in cycle %0d, required %b", cpu_ack, i, exp_ack[i]); else passed++;
         tick();
         if (got === 1'b1) begin
            ci++;
            if (ci == 3) cpu_req = 1'b0;
            else begin
               cpu_address = 16'h0100 + 16'(ci);
               cpu_value   = 16'hC000 + 16'(ci);
            end
         end
      end
      cpu_req = 1'b0;
      wait_quiet("contention");
      total++; if (write_count - w0 != 7 || done_count - d0 != 1)
         $display("FAIL contention_counts: got writes=%0d dones=%0d, required 7 1", write_count - w0, done_count - d0); else passed++;
   endtask

   task automatic test_ignore_start();
      int w0;
      w0 = write_count;
      tick();
      drive_fill(0, 0, 3, 1, 16'h2222);
      push_fill(0, 0, 3, 1, 16'h2222);
      tick();
      drive_fill(10, 3, 5, 5, 16'hDEAD);
      tick();
      fill_start = 1'b0;
      wait_quiet("ignore");
      repeat (5) @(negedge clock);
      total++; if (write_count - w0 != 3)
         $display("FAIL ignore_start_count: got %0d, required 3", write_count - w0); else passed++;
   endtask

   task automatic test_reset_mid_fill();
      int w0;
      int d0;
      d0 = done_count;
      tick();
      drive_fill(0, 4, 8, 2, 16'h4444);
      push_fill(0, 4, 8, 2, 16'h4444);
      tick();
      fill_start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      total++; if (we !== 1'b0 || fill_busy !== 1'b0)
         $display("FAIL mid_reset_outputs: got we=%b busy=%b, required 0 0", we, fill_busy); else passed++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++; if (fill_done !== 1'b0) $display("FAIL mid_reset_done: got %b, required 0", fill_done); else passed++;
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         total++; if (fill_done !== 1'b0 || we !== 1'b0)
            $display("FAIL post_reset_quiet: got done=%b we=%b, required 0 0", fill_done, we); else passed++;
      end
      total++; if (done_count != d0)
         $display("FAIL aborted_done: got %0d dones, required 0", done_count - d0); else passed++;
      w0 = write_count;
      tick();
      drive_fill(5, 0, 2, 1, 16'h3333);
      push_fill(5, 0, 2, 1, 16'h3333);
      tick();
      fill_start = 1'b0;
      wait_quiet("refill");
      total++; if (write_count - w0 != 2 || done_count - d0 != 1)
         $display("FAIL refill_counts: got writes=%0d dones=%0d, required 2 1", write_count - w0, done_count - d0); else passed++;
   endtask

   initial begin
      test_reset();
      test_cpu_single();
      test_fill_basic();
      test_clip_degenerate();
      test_contention();
      test_ignore_start();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/panel_write_arbiter.md
# panel_write_arbiter

Sequences and shares the Panel framebuffer RAM write port (write_address, write_value, we) between a CPU-side single-word requester and a built-in rectangle fill engine. One write reaches the framebuffer per clock at most. Outputs are registered and connect directly to the Panel write inputs. The block sits between the system bus and Panel.

## Interface

Parameters:
- WIDTH, 32: panel columns, pixels per framebuffer row.
- HEIGHT, 16: panel rows.
- ADDR_W, 16: framebuffer address width.
- X_W, 7: column coordinate width.
- Y_W, 5: row coordinate width.

Ports:
- clock, input, 1: single system clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cpu_req, input, 1: CPU write request; held until cpu_ack.
- cpu_address, input, ADDR_W: CPU write address.
- cpu_value, input, 16: CPU write data.
- cpu_ack, output, 1: combinational; high in the cycle the CPU request is granted.
- fill_start, input, 1: one-cycle pulse that starts a fill.
- fill_x, input, X_W: left column of the rectangle.
- fill_y, input, Y_W: top row of the rectangle.
- fill_w, input, X_W: rectangle width in pixels.
- fill_h, input, Y_W: rectangle height in pixels.
- fill_color, input, 16: fill value.
- fill_busy, output, 1: registered; high while a fill is in progress.
- fill_done, output, 1: registered one-cycle pulse when a fill completes.
- write_address, output, ADDR_W: registered, to Panel.
- write_value, output, 16: registered, to Panel.
- we, output, 1: registered write strobe, to Panel.

## Operation

- FSM states:
  - IDLE: no fill pending.
  - FILL: fill writes pending.
  - DONE: one cycle; fill_done=1.
- Start from IDLE:
  - fill_start latches all fill_* inputs.
  - Clip: x_end=min(x+w, WIDTH)-1, y_end=min(y+h, HEIGHT)-1.
  - If w==0, h==0, x>=WIDTH or y>=HEIGHT, the fill is degenerate: go straight to DONE with no writes.
  - Otherwise go to FILL with cursor (x,y).
- fill_start in FILL or DONE is ignored.
- FILL order is row-major:
  - Cursor x increments per granted fill write.
  - At x_end, x resets to the start column and y increments.
  - The grant at (x_end, y_end) moves the FSM to DONE.
- Address arithmetic:
  - address = y*WIDTH + x, computed at ADDR_W width.
  - WIDTH*HEIGHT must be at most 2^ADDR_W.
  - The CPU address passes through unchanged, with no bounds check.
- Arbitration (each cycle; candidates are cpu_req and fill-pending while in FILL):
  - One candidate: it is granted.
  - Both candidates: the requester not granted last time wins.
  - A last_grant bit updates only on contended cycles. It resets to "fill", so the CPU wins the first contention.
  - Result: the CPU and fill alternate strictly under continuous contention; neither starves.
- cpu_ack = cpu_req && CPU granted. The requester may present a new request in the next cycle, allowing back-to-back CPU writes.

## Timing

- Reset values: we=0, write_address=0, write_value=0, fill_busy=0, fill_done=0, FSM=IDLE, last_grant=fill.
- Reset asserted mid-fill aborts the fill; no fill_done is produced.
- Write latency: a grant in cycle N produces we=1 with its address and value in cycle N+1, for one cycle. With no grant, we=0 (address and value hold).
- Start: fill_start in cycle N makes fill_busy=1 from N+1, and the first fill grant can occur in N+1.
- fill_busy stays high through the DONE cycle and drops in the cycle after fill_done.
- The DONE cycle coincides with the last fill write's we cycle, or with N+1 for a degenerate fill.
- Uncontended fill throughput: one pixel per cycle. Under continuous contention: one pixel every 2 cycles.
- A new fill_start is accepted in the cycle after DONE at the earliest.

## Test plan

- Reset with all inputs active: all outputs 0. After release with no stimulus, we stays 0 for 10 cycles.
- CPU single write, address 0x0041, value 0x0007: cpu_ack in the same cycle; next cycle we=1, write_address=0x0041, write_value=0x0007. Two back-to-back requests give two consecutive we cycles.
- Fill x=3, y=1, w=2, h=2, color=0x0005: we on 4 consecutive cycles at addresses 35, 36, 67, 68, value 5. fill_done coincides with the write to 68; fill_busy falls one cycle later.
- Clipping, x=30, y=15, w=5, h=4: writes only to 510 and 511, then fill_done. Degenerate w=0: fill_done at N+1 with no we.
- Contention, fill of 4 pixels with cpu_req held for 3 requests: the CPU wins first, then grants alternate fill/CPU/fill/CPU/fill/fill. All 7 writes are present and correctly ordered.
- fill_start during FILL is ignored (write count unchanged). reset_n pulled low mid-fill: we=0 immediately, no fill_done, and a new fill runs correctly after release.
